// File: rtl/cache_ctrl_fsm_if.sv
// Bus bundle for cache_ctrl_fsm: CPU load/store port, cache_data array
// ports, main-memory handshake and statistics counters.
interface cache_ctrl_fsm_if;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [9:0]  cpu_addr;
    logic [31:0] cpu_wd;
    logic        stall;
    logic        c_we;
    logic [6:0]  c_r_addrs;
    logic [6:0]  c_w_addrs;
    logic [31:0] c_wd;
    logic        mem_rd;
    logic        mem_wr;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    modport master (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wd,
        input  mem_rdata, mem_ready,
        output stall, c_we, c_r_addrs, c_w_addrs, c_wd,
        output mem_rd, mem_wr, mem_addr, mem_wd,
        output hit_cnt, miss_cnt
    );

    modport slave (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wd,
        output mem_rdata, mem_ready,
        input  stall, c_we, c_r_addrs, c_w_addrs, c_wd,
        input  mem_rd, mem_wr, mem_addr, mem_wd,
        input  hit_cnt, miss_cnt
    );
endinterface

// File: rtl/cache_ctrl_fsm.sv
// Direct-mapped write-through, no-write-allocate cache controller, 32x4 words.
// Optional hit/miss counters enabled by defining CACHE_STATS_EN.
module cache_ctrl_fsm (
    input  logic              clk,
    input  logic              rst,
    cache_ctrl_fsm_if.master  bus
);
    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] valid;
    logic [2:0]  tag_ram [32];
    logic [1:0]  k;

    logic [2:0]  tag;
    logic [4:0]  idx;
    logic        hit;
    logic        rd_req;
    logic        wr_req;

    logic        stall;
    logic        c_we;
    logic [6:0]  c_w_addrs;
    logic [31:0] c_wd;
    logic        mem_rd;
    logic        mem_wr;
    logic [9:0]  mem_addr;
    logic        k_inc;
    logic        fill_done;

    assign tag    = bus.cpu_addr[9:7];
    assign idx    = bus.cpu_addr[6:2];
    assign hit    = valid[idx] && (tag_ram[idx] == tag);
    assign wr_req = bus.cpu_wr;
    assign rd_req = bus.cpu_rd && !bus.cpu_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            k     <= 2'd0;
            valid <= 32'd0;
        end else begin
            state <= state_nx;
            if (k_inc)
                k <= k + 2'd1;
            if (fill_done)
                valid[idx] <= 1'b1;
        end
    end

    // Tags need no reset: a tag is only consulted through its valid bit.
    always_ff @(posedge clk) begin
        if (fill_done)
            tag_ram[idx] <= tag;
    end

    always_comb begin
        state_nx  = state;
        stall     = 1'b0;
        c_we      = 1'b0;
        c_w_addrs = 7'd0;
        c_wd      = 32'd0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 10'd0;
        k_inc     = 1'b0;
        fill_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (wr_req) begin
                    stall    = 1'b1;
                    state_nx = WRITE;
                end else if (rd_req && !hit) begin
                    stall    = 1'b1;
                    state_nx = REFILL;
                end
            end
            REFILL: begin
                stall    = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = {tag, idx, k};
                if (bus.mem_ready) begin
                    c_we      = 1'b1;
                    c_w_addrs = {idx, k};
                    c_wd      = bus.mem_rdata;
                    k_inc     = 1'b1;
                    if (k == 2'd3) begin
                        fill_done = 1'b1;
                        state_nx  = IDLE;
                    end
                end
            end
            WRITE: begin
                mem_wr   = 1'b1;
                mem_addr = bus.cpu_addr;
                stall    = !bus.mem_ready;
                if (bus.mem_ready) begin
                    state_nx = IDLE;
                    if (hit) begin
                        c_we      = 1'b1;
                        c_w_addrs = bus.cpu_addr[6:0];
                        c_wd      = bus.cpu_wd;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.stall     = stall;
    assign bus.c_we      = c_we;
    assign bus.c_r_addrs = bus.cpu_addr[6:0];
    assign bus.c_w_addrs = c_w_addrs;
    assign bus.c_wd      = c_wd;
    assign bus.mem_rd    = mem_rd;
    assign bus.mem_wr    = mem_wr;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wd    = bus.cpu_wd;

`ifdef CACHE_STATS_EN
    logic [15:0] hit_q;
    logic [15:0] miss_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q  <= 16'd0;
            miss_q <= 16'd0;
        end else if (state == IDLE && rd_req) begin
            if (hit && hit_q != 16'hFFFF)
                hit_q <= hit_q + 16'd1;
            if (!hit && miss_q != 16'hFFFF)
                miss_q <= miss_q + 16'd1;
        end
    end

    assign bus.hit_cnt  = hit_q;
    assign bus.miss_cnt = miss_q;
`else
    assign bus.hit_cnt  = 16'd0;
    assign bus.miss_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Directed bench for cache_ctrl_fsm with a 1-cycle-latency memory responder.
// Expected counter values follow CACHE_STATS_EN when defined.
module tb_cache_ctrl_fsm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_ctrl_fsm_if bus();

    cache_ctrl_fsm dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [9:0]  ev_maddr [$];
    logic [31:0] ev_mwd   [$];
    logic [6:0]  ev_cwa   [$];
    logic [31:0] ev_cwd   [$];
    int          n_wr_cyc;
    int          n_rd_cyc;
    logic        last_cwe;
    int          cyc;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory: each new request is answered one cycle later.
    initial begin
        logic       pend;
        logic [9:0] paddr;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            pend  = (bus.mem_rd || bus.mem_wr) && !bus.mem_ready;
            paddr = bus.mem_addr;
            @(posedge clk);
            #1;
            bus.mem_ready = pend;
            bus.mem_rdata = pend ? (32'hA0 + 32'(paddr[1:0])) : 32'd0;
        end
    end

    task automatic run_req(input logic rd, input logic wr,
                           input logic [9:0] a, input logic [31:0] d,
                           output int ncyc);
        ev_maddr.delete();
        ev_mwd.delete();
        ev_cwa.delete();
        ev_cwd.delete();
        n_wr_cyc = 0;
        n_rd_cyc = 0;
        last_cwe = 1'b0;
        ncyc     = 0;
        bus.cpu_rd   = rd;
        bus.cpu_wr   = wr;
        bus.cpu_addr = a;
        bus.cpu_wd   = d;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.mem_ready && (bus.mem_rd || bus.mem_wr)) begin
                ev_maddr.push_back(bus.mem_addr);
                ev_mwd.push_back(bus.mem_wd);
            end
            if (bus.c_we) begin
                ev_cwa.push_back(bus.c_w_addrs);
                ev_cwd.push_back(bus.c_wd);
            end
            if (bus.mem_wr) n_wr_cyc++;
            if (bus.mem_rd) n_rd_cyc++;
            last_cwe = bus.c_we;
            if (!bus.stall) begin
                ncyc = i;
                break;
            end
            @(posedge clk);
            #2;
        end
        if (ncyc == 0)
            chk("req_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #2;
        bus.cpu_rd = 1'b0;
        bus.cpu_wr = 1'b0;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bus.cpu_rd = 1'b0;
        bus.cpu_wr = 1'b0;
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] qa(input int i);
        return (i < ev_maddr.size()) ? 32'(ev_maddr[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] qc(input int i);
        return (i < ev_cwa.size()) ? 32'(ev_cwa[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] qd(input int i);
        return (i < ev_cwd.size()) ? ev_cwd[i] : 32'hFFFF_FFFF;
    endfunction

    initial begin
        int n;
        logic [15:0] exp_hit;
        logic [15:0] exp_miss;
        bus.cpu_rd   = 1'b0;
        bus.cpu_wr   = 1'b0;
        bus.cpu_addr = 10'd0;
        bus.cpu_wd   = 32'd0;
        rst          = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        @(negedge clk);
        chk("rst_stall",    32'(bus.stall),     32'd0);
        chk("rst_c_we",     32'(bus.c_we),      32'd0);
        chk("rst_c_waddr",  32'(bus.c_w_addrs), 32'd0);
        chk("rst_c_wd",     bus.c_wd,           32'd0);
        chk("rst_mem_rd",   32'(bus.mem_rd),    32'd0);
        chk("rst_mem_wr",   32'(bus.mem_wr),    32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr),  32'd0);
        chk("rst_hit_cnt",  32'(bus.hit_cnt),   32'd0);
        chk("rst_miss_cnt", 32'(bus.miss_cnt),  32'd0);
        chk("rst_valid",    dut.valid,          32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Read miss on 0x044: refill then hit
        run_req(1'b1, 1'b0, 10'h044, 32'd0, cyc);
        chk("miss_cycles", 32'(cyc), 32'd10);
        chk("miss_nmem", 32'(ev_maddr.size()), 32'd4);
        chk("miss_ncwe", 32'(ev_cwa.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("miss_maddr", qa(i), 32'h044 + 32'(i));
            chk("miss_cwaddr", qc(i), 32'h44 + 32'(i));
            chk("miss_cwd", qd(i), 32'hA0 + 32'(i));
        end
        chk("miss_nowr", 32'(n_wr_cyc), 32'd0);

        // Re-read 0x045 hits with no stall
        bus.cpu_addr = 10'h045;
        @(negedge clk);
        chk("idle_raddr", 32'(bus.c_r_addrs), 32'h45);
        run_req(1'b1, 1'b0, 10'h045, 32'd0, cyc);
        chk("hit_cycles", 32'(cyc), 32'd1);
        chk("hit_nomem", 32'(n_rd_cyc), 32'd0);

        // Write hit 0x045
        run_req(1'b0, 1'b1, 10'h045, 32'hDEADBEEF, cyc);
        chk("wh_cycles", 32'(cyc), 32'd3);
        chk("wh_wr_cyc", 32'(n_wr_cyc), 32'd2);
        chk("wh_maddr", qa(0), 32'h045);
        chk("wh_mwd", (ev_mwd.size() > 0) ? ev_mwd[0] : 32'd0, 32'hDEADBEEF);
        chk("wh_ncwe", 32'(ev_cwa.size()), 32'd1);
        chk("wh_cwaddr", qc(0), 32'h45);
        chk("wh_cwd", qd(0), 32'hDEADBEEF);
        chk("wh_cwe_last", 32'(last_cwe), 32'd1);

        // rd and wr together behave as a write
        run_req(1'b1, 1'b1, 10'h046, 32'h12345678, cyc);
        chk("rw_cycles", 32'(cyc), 32'd3);
        chk("rw_wr_cyc", 32'(n_wr_cyc), 32'd2);
        chk("rw_rd_cyc", 32'(n_rd_cyc), 32'd0);
        chk("rw_cwaddr", qc(0), 32'h46);

        // Conflict on index 17
        run_req(1'b1, 1'b0, 10'h144, 32'd0, cyc);
        chk("cf1_cycles", 32'(cyc), 32'd10);
        chk("cf1_maddr0", qa(0), 32'h144);
        chk("cf1_cwaddr0", qc(0), 32'h44);
        run_req(1'b1, 1'b0, 10'h044, 32'd0, cyc);
        chk("cf2_cycles", 32'(cyc), 32'd10);
        chk("cf2_maddr3", qa(3), 32'h047);

        // Cold write miss 0x3FF: no allocate
        do_reset();
        run_req(1'b0, 1'b1, 10'h3FF, 32'hCAFE0001, cyc);
        chk("wm_cycles", 32'(cyc), 32'd3);
        chk("wm_maddr", qa(0), 32'h3FF);
        chk("wm_ncwe", 32'(ev_cwa.size()), 32'd0);
        run_req(1'b1, 1'b0, 10'h3FF, 32'd0, cyc);
        chk("wm_rd_cycles", 32'(cyc), 32'd10);
        chk("wm_rd_maddr0", qa(0), 32'h3FC);

        // Reset after the second refill word
        bus.cpu_rd   = 1'b1;
        bus.cpu_addr = 10'h044;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.c_we) n++;
            if (n == 2) break;
            @(posedge clk);
            #2;
        end
        chk("ab_words", 32'(n), 32'd2);
        rst        = 1'b1;
        bus.cpu_rd = 1'b0;
        #1;
        chk("ab_state", 32'(dut.state), 32'd0);
        chk("ab_valid17", 32'(dut.valid[17]), 32'd0);
        chk("ab_k", 32'(dut.k), 32'd0);
        chk("ab_stall", 32'(bus.stall), 32'd0);
        chk("ab_mem_rd", 32'(bus.mem_rd), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        run_req(1'b1, 1'b0, 10'h044, 32'd0, cyc);
        chk("ab_cycles", 32'(cyc), 32'd10);
        chk("ab_maddr0", qa(0), 32'h044);
        chk("ab_cwaddr0", qc(0), 32'h44);

        // Counters: miss (ending in a hit) then one more hit
        do_reset();
        run_req(1'b1, 1'b0, 10'h044, 32'd0, cyc);
        run_req(1'b1, 1'b0, 10'h046, 32'd0, cyc);
        run_req(1'b0, 1'b1, 10'h046, 32'd5, cyc);
`ifdef CACHE_STATS_EN
        exp_hit  = 16'd2;
        exp_miss = 16'd1;
`else
        exp_hit  = 16'd0;
        exp_miss = 16'd0;
`endif
        @(negedge clk);
        chk("stat_hit", 32'(bus.hit_cnt), 32'(exp_hit));
        chk("stat_miss", 32'(bus.miss_cnt), 32'(exp_miss));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
